ysyx_23060184_ifu_prefetch: RTL and testbench
=============================================

YSYX_23060184_IFU_PREFETCH -- requirements
Module: ysyx_23060184_ifu_prefetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning instruction, address and PC width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning prefetch buffer entries (power of two, 2..16).
REQ-003 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning first fetch address.
REQ-004 SHALL have one clock; reset is asynchronous and active-high; ports: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-005 SHALL have ports: redirect_valid in 1, PC redirect strobe; redirect_pc in DATA_WIDTH, redirect target.
REQ-006 SHALL have ports: irequest out 1, arbiter request; grant in 1, arbiter grant to this master.
REQ-007 SHALL have ports: araddr out DATA_WIDTH; arvalid out 1; arready in 1; rdata in DATA_WIDTH; rresp in ACERR_WIDTH; rvalid in 1; rready out 1.
REQ-008 SHALL have ports: inst_valid out 1; inst_ready in 1; inst out DATA_WIDTH; inst_pc out DATA_WIDTH; inst_fault out 1.

Function
REQ-009 SHALL run FSM states IDLE, AR, R, DRAIN.
REQ-010 IDLE->AR when credit available: fifo_count + outstanding < FIFO_DEPTH and no redirect this cycle; irequest=1 in AR.
REQ-011 AR: arvalid = grant; araddr = fetch_pc, stable while arvalid=1; on arvalid&arready -> R (or DRAIN if redirect seen while in AR).
REQ-012 R: rready=1; on rvalid push {rdata, pc, fault}, fetch_pc += 4 (mod 2^DATA_WIDTH, wrap silent), -> IDLE.
REQ-013 DRAIN: rready=1; on rvalid discard beat, -> IDLE; no FIFO push.
REQ-014 Redirect in IDLE: fetch_pc<=redirect_pc, FIFO flushed same edge.
REQ-015 Redirect in AR: FIFO flushed, fetch_pc<=redirect_pc, address phase completes unchanged, then DRAIN.
REQ-016 Redirect in R with rvalid same cycle: beat discarded, -> IDLE; without rvalid: -> DRAIN.
REQ-017 Redirect and inst_valid&inst_ready same cycle: flush wins, popped entry still counts as consumed downstream.
REQ-018 FIFO: inst_valid = !empty; inst/inst_pc/inst_fault from head, combinational; pop on inst_valid&inst_ready.
REQ-019 Simultaneous push and pop when full SHALL be accepted (pop frees slot); credit rule makes push-on-full without pop impossible.
REQ-020 Fetch latency: redirect to first inst_valid >= 3 cycles (IDLE,AR,R) with zero-wait memory.

Reset
REQ-021 On rst: state=IDLE, fetch_pc=RESET_PC, FIFO empty, outstanding=0.
REQ-022 Reset outputs: arvalid=0, rready=0, irequest=0, inst_valid=0, inst_fault=0, araddr=RESET_PC.
REQ-023 Reset mid-transaction SHALL abandon the transaction; the interconnect is reset simultaneously.

Configuration
REQ-024 With YSYX_IFU_ACCESS_FAULT_EN defined: rresp!=0 sets inst_fault=1, inst=0, and fetching halts (IDLE, no requests) until redirect.
REQ-025 Without it: rresp ignored, inst_fault tied 0, fetching continues.

Structure
REQ-026 FSM state encoding, ACERR_WIDTH and OKAY response constant SHALL live in the shared ysyx_23060184 package/defines.
REQ-027 FIFO SHALL be sub-module ysyx_23060184_sync_fifo (parameters WIDTH, DEPTH, flush input).

Verification
REQ-028 Reset release, inst_ready=1, zero-wait memory -> araddr 0x80000000, 0x80000004, 0x80000008; inst_pc matches in order.
REQ-029 inst_ready=0 with FIFO_DEPTH=4 -> exactly 4 reads issued, irequest stays 0, inst_valid held, head stable.
REQ-030 Redirect to 0x80001000 while in R, rvalid 2 cycles later -> stale beat dropped, next araddr 0x80001000, no stale inst_valid.
REQ-031 grant=0 for 5 cycles in AR -> arvalid=0, irequest=1, araddr unchanged; grant=1 -> handshake.
REQ-032 rresp=2'b10 with macro -> inst_fault=1, no further arvalid until redirect; without macro -> inst_fault=0, fetch continues.
REQ-033 fetch_pc 0xFFFF_FFFC -> next araddr 0x0000_0000.

Source files
------------

// File: rtl/ysyx_23060184_pkg.sv
// rtl/ysyx_23060184_pkg.sv - shared IFU fetch states and bus response constants
package ysyx_23060184_pkg;

   localparam int ACERR_WIDTH = 2;
   localparam logic [ACERR_WIDTH-1:0] RESP_OKAY = '0;

   typedef enum logic [1:0] {
      IFU_IDLE  = 2'd0,
      IFU_AR    = 2'd1,
      IFU_R     = 2'd2,
      IFU_DRAIN = 2'd3
   } ifu_state_e;

endpackage

// File: rtl/ysyx_23060184_sync_fifo.sv
// rtl/ysyx_23060184_sync_fifo.sv - synchronous FIFO with flush and combinational head
module ysyx_23060184_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // A pop on a full FIFO frees the slot the simultaneous push lands in.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/ysyx_23060184_ifu_prefetch.sv
// rtl/ysyx_23060184_ifu_prefetch.sv - instruction prefetcher; YSYX_IFU_ACCESS_FAULT_EN enables fault reporting
module ysyx_23060184_ifu_prefetch
   import ysyx_23060184_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    redirect_valid,
   input  logic [DATA_WIDTH-1:0]   redirect_pc,
   output logic                    irequest,
   input  logic                    grant,
   output logic [DATA_WIDTH-1:0]   araddr,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [ACERR_WIDTH-1:0]  rresp,
   input  logic                    rvalid,
   output logic                    rready,
   output logic                    inst_valid,
   input  logic                    inst_ready,
   output logic [DATA_WIDTH-1:0]   inst,
   output logic [DATA_WIDTH-1:0]   inst_pc,
   output logic                    inst_fault
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = 2 * DATA_WIDTH + 1;

   ifu_state_e            state_q;
   logic [DATA_WIDTH-1:0] fetch_pc_q;
   logic [DATA_WIDTH-1:0] ar_addr_q;
   logic                  irequest_q, rready_q, drain_q, halt_q;

   logic [CW-1:0]         fifo_count;
   logic                  fifo_empty, unused_fifo_full;
   logic                  push, pop, outstanding, credit, beat_fault;
   logic [DATA_WIDTH-1:0] push_inst;
   logic [EW-1:0]         push_entry, head_entry;

`ifdef YSYX_IFU_ACCESS_FAULT_EN
   assign beat_fault = (rresp != RESP_OKAY);
`else
   logic unused_rresp;
   assign unused_rresp = ^rresp;
   assign beat_fault   = 1'b0;
`endif

   // A read already past IDLE reserves a slot unless its beat will be dropped.
   assign outstanding = ((state_q == IFU_AR) && !drain_q) || (state_q == IFU_R);
   assign credit      = (fifo_count + CW'(outstanding)) < CW'(FIFO_DEPTH);

   assign push       = (state_q == IFU_R) && rvalid && !redirect_valid;
   assign pop        = !fifo_empty && inst_ready;
   assign push_inst  = beat_fault ? '0 : rdata;
   assign push_entry = {push_inst, ar_addr_q, beat_fault};

   ysyx_23060184_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_valid),
      .push_i  (push),
      .wdata_i (push_entry),
      .pop_i   (pop),
      .rdata_o (head_entry),
      .empty_o (fifo_empty),
      .full_o  (unused_fifo_full),
      .count_o (fifo_count)
   );

   assign irequest   = irequest_q;
   assign arvalid    = irequest_q && grant;
   assign araddr     = ar_addr_q;
   assign rready     = rready_q;
   assign inst_valid = !fifo_empty;
   assign inst       = head_entry[EW-1 -: DATA_WIDTH];
   assign inst_pc    = head_entry[DATA_WIDTH:1];
   assign inst_fault = !fifo_empty && head_entry[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IFU_IDLE;
         fetch_pc_q <= RESET_PC;
         ar_addr_q  <= RESET_PC;
         irequest_q <= 1'b0;
         rready_q   <= 1'b0;
         drain_q    <= 1'b0;
         halt_q     <= 1'b0;
      end else begin
         if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
            halt_q     <= 1'b0;
         end
         case (state_q)
            IFU_IDLE: begin
               if (!redirect_valid && credit && !halt_q) begin
                  state_q    <= IFU_AR;
                  irequest_q <= 1'b1;
                  ar_addr_q  <= fetch_pc_q;
               end
            end
            IFU_AR: begin
               // The address phase always completes; a redirect only marks the beat for dropping.
               if (redirect_valid) drain_q <= 1'b1;
               if (irequest_q && grant && arready) begin
                  irequest_q <= 1'b0;
                  rready_q   <= 1'b1;
                  drain_q    <= 1'b0;
                  state_q    <= (drain_q || redirect_valid) ? IFU_DRAIN : IFU_R;
               end
            end
            IFU_R: begin
               if (rvalid) begin
                  rready_q <= 1'b0;
                  state_q  <= IFU_IDLE;
                  if (!redirect_valid) begin
                     fetch_pc_q <= fetch_pc_q + DATA_WIDTH'(4);
                     halt_q     <= beat_fault;
                  end
               end else if (redirect_valid) begin
                  state_q <= IFU_DRAIN;
               end
            end
            IFU_DRAIN: begin
               if (rvalid) begin
                  rready_q <= 1'b0;
                  state_q  <= IFU_IDLE;
               end
            end
            default: state_q <= IFU_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060184_ifu_prefetch.sv
// tb/tb_ysyx_23060184_ifu_prefetch.sv - directed vector bench for the IFU prefetcher
module tb_ysyx_23060184_ifu_prefetch;
   import ysyx_23060184_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   redirect_valid = 1'b0;
   logic [31:0]            redirect_pc = '0;
   logic                   irequest, grant = 1'b1;
   logic [31:0]            araddr;
   logic                   arvalid, arready = 1'b1;
   logic [31:0]            rdata = '0;
   logic [ACERR_WIDTH-1:0] rresp = '0;
   logic                   rvalid = 1'b0, rready;
   logic                   inst_valid, inst_ready = 1'b1;
   logic [31:0]            inst, inst_pc;
   logic                   inst_fault;

   ysyx_23060184_ifu_prefetch dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .irequest(irequest), .grant(grant), .araddr(araddr), .arvalid(arvalid),
      .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .inst_fault(inst_fault)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   // Memory: beat returned mem_delay cycles after the address handshake, data = addr ^ 0x12345678.
   int          mem_delay  = 0;
   logic [31:0] fault_addr = 32'h1;
   logic        ar_hs, r_hs, pend = 1'b0;
   logic [31:0] ar_a, paddr;
   int          pdly;

   always begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      ar_a  = araddr;
      @(posedge clk);
      #1;
      if (rst) begin
         pend   = 1'b0;
         rvalid = 1'b0;
      end else begin
         if (r_hs) rvalid = 1'b0;
         if (ar_hs) begin
            pend  = 1'b1;
            pdly  = mem_delay;
            paddr = ar_a;
         end
         if (pend && !rvalid) begin
            if (pdly == 0) begin
               rvalid = 1'b1;
               rdata  = paddr ^ 32'h1234_5678;
               rresp  = (paddr == fault_addr) ? 2'b10 : 2'b00;
               pend   = 1'b0;
            end else begin
               pdly--;
            end
         end
      end
   end

   int          hs_cnt = 0;
   logic [31:0] hs_addr[$];
   logic [31:0] pop_pc[$];
   logic [31:0] pop_inst[$];
   logic [31:0] pop_fault[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (arvalid && arready) begin
            hs_cnt++;
            hs_addr.push_back(araddr);
         end
         if (inst_valid && inst_ready) begin
            pop_pc.push_back(inst_pc);
            pop_inst.push_back(inst);
            pop_fault.push_back({31'b0, inst_fault});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      grant = 1'b1;
      inst_ready = 1'b1;
      mem_delay = 0;
      fault_addr = 32'h1;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      hs_cnt = 0;
      hs_addr.delete();
      pop_pc.delete();
      pop_inst.delete();
      pop_fault.delete();
   endtask

   typedef struct {
      logic        grant;
      logic        inst_ready;
      logic        exp_irequest;
      logic        exp_arvalid;
      logic        exp_rready;
      logic        chk_addr;
      logic [31:0] exp_araddr;
      logic        exp_inst_valid;
      logic [31:0] exp_inst_pc;
      logic [31:0] exp_inst;
   } vec_t;

   vec_t vecs[10];

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      int n0;

      vecs[0] = '{1, 1, 0, 0, 0, 1, 32'h8000_0000, 0, 32'h0, 32'h0};
      vecs[1] = '{1, 1, 1, 1, 0, 1, 32'h8000_0000, 0, 32'h0, 32'h0};
      vecs[2] = '{1, 1, 0, 0, 1, 0, 32'h0,         0, 32'h0, 32'h0};
      vecs[3] = '{1, 1, 0, 0, 0, 0, 32'h0,         1, 32'h8000_0000, 32'h9234_5678};
      vecs[4] = '{1, 1, 1, 1, 0, 1, 32'h8000_0004, 0, 32'h0, 32'h0};
      vecs[5] = '{1, 1, 0, 0, 1, 0, 32'h0,         0, 32'h0, 32'h0};
      vecs[6] = '{1, 1, 0, 0, 0, 0, 32'h0,         1, 32'h8000_0004, 32'h9234_567C};
      vecs[7] = '{1, 1, 1, 1, 0, 1, 32'h8000_0008, 0, 32'h0, 32'h0};
      vecs[8] = '{1, 1, 0, 0, 1, 0, 32'h0,         0, 32'h0, 32'h0};
      vecs[9] = '{1, 1, 0, 0, 0, 0, 32'h0,         1, 32'h8000_0008, 32'h9234_5670};

      // Cycle-by-cycle fetch stream after reset release.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         grant = vecs[i].grant;
         inst_ready = vecs[i].inst_ready;
         @(negedge clk);
         check($sformatf("seq%0d irequest", i), irequest, vecs[i].exp_irequest);
         check($sformatf("seq%0d arvalid", i), arvalid, vecs[i].exp_arvalid);
         check($sformatf("seq%0d rready", i), rready, vecs[i].exp_rready);
         check($sformatf("seq%0d inst_valid", i), inst_valid, vecs[i].exp_inst_valid);
         check($sformatf("seq%0d inst_fault", i), inst_fault, 0);
         if (vecs[i].chk_addr) check($sformatf("seq%0d araddr", i), araddr, vecs[i].exp_araddr);
         if (vecs[i].exp_inst_valid) begin
            check($sformatf("seq%0d inst_pc", i), inst_pc, vecs[i].exp_inst_pc);
            check($sformatf("seq%0d inst", i), inst, vecs[i].exp_inst);
         end
         step();
      end

      // Stalled consumer: credit stops fetching at FIFO_DEPTH reads, then redirect flushes.
      do_reset();
      inst_ready = 1'b0;
      repeat (30) step();
      check("stall read count", hs_cnt, 4);
      @(negedge clk);
      check("stall irequest", irequest, 0);
      check("stall inst_valid", inst_valid, 1);
      check("stall head pc", inst_pc, 32'h8000_0000);
      check("stall head inst", inst, 32'h9234_5678);
      step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_2000;
      inst_ready = 1'b1;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("flush inst_valid", inst_valid, 0);
      step();
      n0 = pop_pc.size();
      check("flush pop counted", n0, 1);
      check("flush popped pc", qget(pop_pc, 0), 32'h8000_0000);
      k = 0;
      while (pop_pc.size() <= n0 && k < 30) begin step(); k++; end
      check("post-flush first pc", qget(pop_pc, n0), 32'h8000_2000);
      check("post-flush araddr", qget(hs_addr, 4), 32'h8000_2000);

      // Grant withheld in AR.
      do_reset();
      grant = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("nogrant%0d arvalid", i), arvalid, 0);
         check($sformatf("nogrant%0d irequest", i), irequest, 1);
         check($sformatf("nogrant%0d araddr", i), araddr, 32'h8000_0000);
         step();
      end
      grant = 1'b1;
      @(negedge clk);
      check("grant arvalid", arvalid, 1);
      step();
      check("grant handshake", hs_cnt, 1);

      // Redirect while in R, stale beat arrives later and must be dropped.
      do_reset();
      mem_delay = 2;
      k = 0;
      while (!rready && k < 20) begin step(); k++; end
      check("reach R", rready, 1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_1000;
      step();
      redirect_valid = 1'b0;
      mem_delay = 0;
      k = 0;
      while (pop_pc.size() == 0 && k < 30) begin step(); k++; end
      check("redirect first pc", qget(pop_pc, 0), 32'h8000_1000);
      check("redirect next araddr", qget(hs_addr, 1), 32'h8000_1000);

      // PC wraps through zero.
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      k = 0;
      while (pop_pc.size() < 2 && k < 30) begin step(); k++; end
      check("wrap araddr0", qget(hs_addr, 0), 32'hFFFF_FFFC);
      check("wrap araddr1", qget(hs_addr, 1), 32'h0000_0000);
      check("wrap inst_pc1", qget(pop_pc, 1), 32'h0000_0000);
      check("wrap inst1", qget(pop_inst, 1), 32'h1234_5678);

      // Error response on the second fetch.
      do_reset();
      fault_addr = 32'h8000_0004;
      repeat (20) step();
`ifdef YSYX_IFU_ACCESS_FAULT_EN
      check("fault flag", qget(pop_fault, 1), 1);
      check("fault inst", qget(pop_inst, 1), 0);
      check("fault halts reads", hs_cnt, 2);
      check("fault irequest", irequest, 0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_3000;
      step();
      redirect_valid = 1'b0;
      repeat (10) step();
      check("fault resume araddr", qget(hs_addr, 2), 32'h8000_3000);
`else
      check("fault flag", qget(pop_fault, 1), 0);
      check("fault inst", qget(pop_inst, 1), 32'h9234_567C);
      check("fault fetch continues", (hs_cnt > 2) ? 1 : 0, 1);
      check("fault next pc", qget(pop_pc, 2), 32'h8000_0008);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
